// File: rtl/demux_dispatch_sequencer_if.sv
// Request and demux-drive signal bundle for demux_dispatch_sequencer.
// The master side issues requests; the slave side is the sequencer itself.
interface demux_dispatch_sequencer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic [2:0]    req_sel;
    logic          req_data;
    logic          req_ready;
    logic [2:0]    dmx_sel;
    logic          dmx_in;
    logic          busy;
    logic          done_pulse;
    logic [CW-1:0] fifo_count;

    modport master (
        output req_valid, req_sel, req_data,
        input  req_ready, dmx_sel, dmx_in, busy, done_pulse, fifo_count
    );

    modport slave (
        input  req_valid, req_sel, req_data,
        output req_ready, dmx_sel, dmx_in, busy, done_pulse, fifo_count
    );
endinterface

// File: rtl/demux_dispatch_sequencer.sv
// Buffers routing requests in a FIFO and replays each one onto the 1x8 demux
// for a fixed hold window plus guard gap, so sel never moves while in is high.
module demux_dispatch_sequencer #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    demux_dispatch_sequencer_if.slave bus
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GUARD = 2'd2
    } state_t;

    logic [3:0]    mem_r [DEPTH];
    logic [PW:0]   wr_ptr_r, rd_ptr_r;
    logic [PW:0]   count_s, count_next_s;
    logic          full_s, empty_s, push_s, pop_s, load_s;
    logic [3:0]    head_s;
    state_t        state_r, state_next_s;
    logic [CW-1:0] cnt_r, cnt_next_s;
    logic [2:0]    sel_r, sel_next_s;
    logic          in_r, in_next_s;
    logic          done_r, done_next_s;
    logic          busy_r, busy_next_s;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign count_s      = wr_ptr_r - rd_ptr_r;
    assign full_s       = (count_s == (PW+1)'(DEPTH));
    assign empty_s      = (count_s == {(PW+1){1'b0}});
    assign push_s       = bus.req_valid && !full_s;
    assign head_s       = mem_r[rd_ptr_r[PW-1:0]];
    assign count_next_s = count_s + (PW+1)'(push_s) - (PW+1)'(pop_s);

    assign bus.req_ready  = !full_s;
    assign bus.fifo_count = count_s;
    assign bus.dmx_sel    = sel_r;
    assign bus.dmx_in     = in_r;
    assign bus.done_pulse = done_r;
    assign bus.busy       = busy_r;

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 4'b0000;
            end
            wr_ptr_r <= {(PW+1){1'b0}};
            rd_ptr_r <= {(PW+1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[PW-1:0]] <= {bus.req_data, bus.req_sel};
                wr_ptr_r                <= wr_ptr_r + (PW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (PW+1)'(1);
            end
        end
    end

    // Sequencer state and registered demux outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            sel_r   <= 3'b000;
            in_r    <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            sel_r   <= sel_next_s;
            in_r    <= in_next_s;
            done_r  <= done_next_s;
            busy_r  <= busy_next_s;
        end
    end

    // Next-state logic; load_s marks every edge that pops a request into DRIVE.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        sel_next_s   = sel_r;
        in_next_s    = in_r;
        load_s       = 1'b0;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                in_next_s = 1'b0;
                if (!empty_s) begin
                    load_s = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_r == {CW{1'b0}}) begin
                    if (GAP > 0) begin
                        in_next_s    = 1'b0;
                        cnt_next_s   = CW'(GAP - 1);
                        state_next_s = GUARD;
                    end else if (!empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        in_next_s    = 1'b0;
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - CW'(1);
                end
            end
            GUARD: begin
                in_next_s = 1'b0;
                if (cnt_r == {CW{1'b0}}) begin
                    if (!empty_s) begin
                        load_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - CW'(1);
                end
            end
            default: begin
                in_next_s    = 1'b0;
                state_next_s = IDLE;
            end
        endcase
        if (load_s) begin
            pop_s        = 1'b1;
            sel_next_s   = head_s[2:0];
            in_next_s    = head_s[3];
            cnt_next_s   = CW'(HOLD - 1);
            state_next_s = DRIVE;
        end else begin
            pop_s = 1'b0;
        end
        done_next_s = (state_next_s == DRIVE) && (cnt_next_s == {CW{1'b0}});
        busy_next_s = (state_next_s != IDLE) || (count_next_s != {(PW+1){1'b0}});
    end
endmodule

// File: doc/demux_dispatch_sequencer.md
Name: demux_dispatch_sequencer

Overview:
Upstream driver for the 1x8 demultiplexer. It accepts routing requests (3-bit destination plus 1-bit data) over a valid/ready handshake and buffers them in a small FIFO. It plays each request onto the demux `in`/`sel` lines for a fixed hold window, followed by a guard gap. This guarantees `sel` never changes while `in` is asserted, so the demux outputs stay glitch-free.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
HOLD, 3, cycles dmx_in/dmx_sel are driven per request (>=1)
GAP, 1, idle cycles after each hold window with dmx_in=0 (>=0; 0 = back-to-back)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_sel  input  3  destination output index 0..7
req_data  input  1  bit to route
req_ready  output  1  FIFO can accept (= !full)
dmx_sel  output  3  to demux sel
dmx_in  output  1  to demux in
busy  output  1  FSM not in IDLE, or FIFO non-empty
done_pulse  output  1  one-cycle strobe on last HOLD cycle of each request
fifo_count  output  clog2(DEPTH)+1  entries held

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset (async assert, sync release):
  - FIFO empty; state IDLE; fifo_count=0.
  - dmx_sel=0, dmx_in=0, done_pulse=0, busy=0.
  - req_ready=1 once out of reset.
- Reset mid-request aborts immediately. The entry being driven and all queued entries are discarded; no done_pulse is produced.
- Push: on a clk edge with req_valid && req_ready, {req_data, req_sel} is written at the write pointer.
  - Pointers wrap modulo DEPTH.
  - When full, req_ready=0 and req_valid is ignored, even in a cycle where the FSM pops. A slot freed by a pop becomes visible as req_ready=1 on the following cycle.
- Pop and simultaneous push on a non-full FIFO: both happen and fifo_count is unchanged.
- All dmx_*, done_pulse, and busy are registered. req_ready and fifo_count are derived from registered state only.
- FSM states: IDLE, DRIVE, GUARD.
  - IDLE: dmx_in=0, dmx_sel holds its last value.
    - If FIFO non-empty: pop, load dmx_sel=entry.sel and dmx_in=entry.data, load hold counter with HOLD-1, go to DRIVE.
    - A request accepted on edge E0 appears on dmx_* after edge E1 (1-cycle latency from an empty, idle state).
  - DRIVE: dmx_sel/dmx_in held constant. Counter decrements each cycle.
    - done_pulse=1 during the cycle where counter==0.
    - At counter==0 with GAP>0: dmx_in<=0, dmx_sel held, load gap counter with GAP-1, go to GUARD.
    - At counter==0 with GAP==0:
      - FIFO non-empty: pop the next entry directly into DRIVE (back-to-back; sel may change together with in).
      - FIFO empty: dmx_in<=0, go to IDLE.
  - GUARD: dmx_in=0, dmx_sel held. At gap counter==0:
    - FIFO non-empty: pop the next entry and go to DRIVE.
    - FIFO empty: go to IDLE.
- Sequence and period:
  - dmx_sel only changes on the edge that enters DRIVE. With GAP>=1, it never changes while dmx_in=1.
  - Each request occupies exactly HOLD cycles of DRIVE. The request-to-request period with a non-empty FIFO is HOLD+GAP cycles.
- Requests with req_data=0 still go through a full HOLD+GAP window (dmx_in=0 throughout DRIVE) and still produce done_pulse.
- Ordering is strict FIFO; no request is dropped or duplicated.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, assert req_valid -> all outputs 0, fifo_count=0, no push. Release reset -> req_ready=1, dmx_in=0.
2. Single request sel=3'b001, data=1, accepted at edge E0 -> at E1 dmx_sel=001, dmx_in=1 for exactly 3 cycles; done_pulse on the 3rd cycle. Then dmx_in=0 for 1 GUARD cycle, then IDLE with busy=0.
3. Burst of 5 requests sel=101,011,111,010,001 (data=1) presented back-to-back with DEPTH=4:
   - req_ready drops when full.
   - Outputs appear in exact order with a 4-cycle period.
   - dmx_sel changes only while dmx_in=0.
   - 5 done_pulses are produced.
4. Wrap-around: push/pop 10 requests with random sel and data -> order preserved across pointer wrap; fifo_count never exceeds 4.
5. Simultaneous push and pop: FIFO holds 2 entries, push on the pop edge -> fifo_count stays 2 and the new entry is drained last.
6. Reset asserted in the 2nd DRIVE cycle of sel=110 with 2 entries queued -> dmx_in=0 and dmx_sel=0 immediately (asynchronous). After release, FIFO is empty, no done_pulse occurs, and a new request sel=100 plays normally.
7. GAP=0 build, two queued requests sel=011 then 101 -> 6 consecutive DRIVE cycles, with dmx_sel switching 011->101 at the 3-cycle boundary.
